// File: rtl/gated_pulse_counter.sv
// gated_pulse_counter
//   Counts detector pulses inside a gate window and hands one result per
//   window downstream over a valid/ready handshake. The detector input is
//   asynchronous and is synchronised here; the gate is already synchronous.
//
//   Optional feature: define GATED_COUNTER_GATE_LENGTH_EN to add the
//   gate_len_out port, which reports the number of gate-high cycles of the
//   window alongside its pulse count.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous, active-high reset
//   gate          counting window (synchronous to clk)
//   enable        arms a window; sampled only on a gate rising edge
//   pulse         asynchronous detector input
//   count_out     pulse count of the last completed window
//   overflow_out  counter saturated during that window
//   valid         result available
//   ready         downstream accepts the result
//   dropped       results discarded while the output register was full (saturating)
//   gate_len_out  gate-high cycles of the window (GATED_COUNTER_GATE_LENGTH_EN only)
module gated_pulse_counter #(
  parameter int COUNT_WIDTH = 32,
  parameter int DROP_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gate,
  input  logic                   enable,
  input  logic                   pulse,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   overflow_out,
  output logic                   valid,
  input  logic                   ready,
  output logic [DROP_WIDTH-1:0]  dropped
`ifdef GATED_COUNTER_GATE_LENGTH_EN
  ,
  output logic [31:0]            gate_len_out
`endif
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};
  localparam logic [DROP_WIDTH-1:0]  DROP_ONE = DROP_WIDTH'(1);
  localparam logic [DROP_WIDTH-1:0]  DROP_MAX = {DROP_WIDTH{1'b1}};

  typedef enum logic {IDLE, COUNTING} state_t;

  function automatic logic [COUNT_WIDTH-1:0] cnt_sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [DROP_WIDTH-1:0] drop_sat_inc(input logic [DROP_WIDTH-1:0] v);
    return (v == DROP_MAX) ? v : v + DROP_ONE;
  endfunction

`ifdef GATED_COUNTER_GATE_LENGTH_EN
  function automatic logic [31:0] len_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] len;
`endif

  state_t                 state;
  logic                   s1, s2, s3;
  logic                   gate_d;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   ovf;
  logic                   pulse_edge;
  logic                   rise;
  logic                   fall;

  // Input stage: two-flop synchroniser plus one history flop for edge detect.
  // gate_d resets high so a gate already high at reset release is not a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      gate_d <= 1'b1;
    end else begin
      s1     <= pulse;
      s2     <= s1;
      s3     <= s2;
      gate_d <= gate;
    end
  end

  assign pulse_edge = s2 & ~s3;
  assign rise       = gate & ~gate_d;
  assign fall       = ~gate & gate_d;

  // Window FSM, counter and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ovf          <= 1'b0;
      count_out    <= '0;
      overflow_out <= 1'b0;
      valid        <= 1'b0;
      dropped      <= '0;
`ifdef GATED_COUNTER_GATE_LENGTH_EN
      len          <= 32'd0;
      gate_len_out <= 32'd0;
`endif
    end else begin
      // A transfer retires the held result; a load below overrides this.
      if (valid && ready) begin
        valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          // A rise without enable leaves the whole window uncounted.
          if (rise && enable) begin
            state <= COUNTING;
            cnt   <= {{(COUNT_WIDTH-1){1'b0}}, pulse_edge};
            ovf   <= 1'b0;
`ifdef GATED_COUNTER_GATE_LENGTH_EN
            len   <= 32'd1;
`endif
          end
        end
        COUNTING: begin
          if (fall) begin
            state <= IDLE;
            if (!valid || ready) begin
              count_out    <= cnt;
              overflow_out <= ovf;
              valid        <= 1'b1;
`ifdef GATED_COUNTER_GATE_LENGTH_EN
              gate_len_out <= len;
`endif
            end else begin
              dropped <= drop_sat_inc(dropped);
            end
          end else if (gate) begin
            if (pulse_edge) begin
              if (cnt == CNT_MAX) begin
                ovf <= 1'b1;
              end
              cnt <= cnt_sat_inc(cnt);
            end
`ifdef GATED_COUNTER_GATE_LENGTH_EN
            len <= len_sat_inc(len);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gated_pulse_counter.sv
// Bench for gated_pulse_counter: directed scenarios built from per-cycle
// stimulus maps, followed by a randomized run, all checked every cycle
// against a behavioural window model.
module tb_gated_pulse_counter;

  localparam int CW   = 4;
  localparam int DW   = 3;
  localparam int CMAX = 15;
  localparam int DMAX = 7;
  localparam longint LMAX = 64'h0000_0000_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          gate = 1'b0;
  logic          enable = 1'b0;
  logic          pulse = 1'b0;
  logic          ready = 1'b0;
  logic [CW-1:0] count_out;
  logic          overflow_out;
  logic          valid;
  logic [DW-1:0] dropped;
`ifdef GATED_COUNTER_GATE_LENGTH_EN
  logic [31:0]   gate_len_out;
`endif

  gated_pulse_counter #(.COUNT_WIDTH(CW), .DROP_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .gate(gate),
    .enable(enable),
    .pulse(pulse),
    .count_out(count_out),
    .overflow_out(overflow_out),
    .valid(valid),
    .ready(ready),
    .dropped(dropped)
`ifdef GATED_COUNTER_GATE_LENGTH_EN
    ,
    .gate_len_out(gate_len_out)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit     m_prev_gate;
  bit     m_in_win;
  int     m_cnt;
  bit     m_ovf;
  longint m_len;
  int     m_oc;
  bit     m_oo;
  bit     m_ov;
  int     m_drop;
  longint m_olen;
  bit     pq[$];   // pulse values sampled at successive clock edges

  task automatic model_reset();
    m_prev_gate = 1'b1;
    m_in_win = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_len = 0;
    m_oc = 0;
    m_oo = 1'b0;
    m_ov = 1'b0;
    m_drop = 0;
    m_olen = 0;
    pq = {};
    for (int i = 0; i < 3; i++) pq.push_back(1'b0);
  endtask

  task automatic model_step(input bit g, input bit en, input bit p, input bit rd, input bit r);
    bit edge_seen, rise_m, fall_m, load;
    if (r) begin
      model_reset();
      return;
    end
    // A pulse first sampled high two edges ago, low three edges ago.
    edge_seen = pq[pq.size()-2] && !pq[pq.size()-3];
    rise_m = g && !m_prev_gate;
    fall_m = !g && m_prev_gate;
    load = 1'b0;
    if (!m_in_win) begin
      if (rise_m && en) begin
        m_in_win = 1'b1;
        m_cnt = edge_seen ? 1 : 0;
        m_ovf = 1'b0;
        m_len = 1;
      end
    end else if (fall_m) begin
      m_in_win = 1'b0;
      load = 1'b1;
    end else if (g) begin
      if (edge_seen) begin
        if (m_cnt == CMAX) m_ovf = 1'b1;
        else m_cnt = m_cnt + 1;
      end
      if (m_len < LMAX) m_len = m_len + 1;
    end
    if (load && (!m_ov || rd)) begin
      m_oc = m_cnt;
      m_oo = m_ovf;
      m_olen = m_len;
      m_ov = 1'b1;
    end else begin
      if (load) m_drop = (m_drop < DMAX) ? m_drop + 1 : DMAX;
      if (m_ov && rd) m_ov = 1'b0;
    end
    m_prev_gate = g;
    pq.push_back(p);
    if (pq.size() > 4) void'(pq.pop_front());
  endtask

  // ---------------- stimulus helpers ----------------
  int     xf_cnt[$];
  int     xf_ovf[$];
  longint xf_len[$];

  bit gmap[256];
  bit emap[256];
  bit pmap[256];
  bit rmap[256];
  bit xmap[256];

  task automatic cyc(input bit g, input bit en, input bit p, input bit rd, input bit r);
    gate = g;
    enable = en;
    pulse = p;
    ready = rd;
    rst = r;
    if (!r && rd && valid === 1'b1) begin
      xf_cnt.push_back(int'(count_out));
      xf_ovf.push_back(int'(overflow_out));
`ifdef GATED_COUNTER_GATE_LENGTH_EN
      xf_len.push_back(longint'(gate_len_out));
`endif
    end
    model_step(g, en, p, rd, r);
    @(posedge clk);
    #1;
    chk("valid", valid, m_ov);
    chk("count_out", count_out, m_oc);
    chk("overflow_out", overflow_out, m_oo);
    chk("dropped", dropped, m_drop);
`ifdef GATED_COUNTER_GATE_LENGTH_EN
    chk("gate_len_out", gate_len_out, m_olen);
`endif
  endtask

  task automatic clear_maps(input bit en, input bit rd);
    for (int i = 0; i < 256; i++) begin
      gmap[i] = 1'b0;
      emap[i] = en;
      pmap[i] = 1'b0;
      rmap[i] = rd;
      xmap[i] = 1'b0;
    end
    xf_cnt = {};
    xf_ovf = {};
    xf_len = {};
  endtask

  task automatic set_gate(input int from, input int upto);
    for (int i = from; i <= upto; i++) gmap[i] = 1'b1;
  endtask

  task automatic set_pulse(input int start, input int width);
    for (int i = start; i < start + width; i++) pmap[i] = 1'b1;
  endtask

  task automatic run_maps(input int n);
    for (int c = 0; c < n; c++) cyc(gmap[c], emap[c], pmap[c], rmap[c], xmap[c]);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_valid", valid, 0);
    chk("reset_count", count_out, 0);
    chk("reset_dropped", dropped, 0);

    // Basic window: 20 gate cycles, 5 three-cycle pulses, first edge on the rise.
    clear_maps(1'b1, 1'b1);
    set_gate(5, 24);
    for (int k = 0; k < 5; k++) set_pulse(3 + 4 * k, 3);
    run_maps(35);
    chk("basic_nxfer", xf_cnt.size(), 1);
    chk("basic_cnt", (xf_cnt.size() > 0) ? xf_cnt[0] : -1, 5);
    chk("basic_ovf", (xf_ovf.size() > 0) ? xf_ovf[0] : -1, 0);
`ifdef GATED_COUNTER_GATE_LENGTH_EN
    chk("basic_len", (xf_len.size() > 0) ? xf_len[0] : -1, 20);
`endif

    // Window edges: edge one cycle before rise and on the fall cycle are not
    // counted; a one-cycle gate counts a coincident edge.
    clear_maps(1'b1, 1'b1);
    set_gate(5, 14);
    set_pulse(2, 3);
    set_pulse(13, 3);
    set_gate(20, 20);
    set_pulse(18, 1);
    run_maps(30);
    chk("edges_nxfer", xf_cnt.size(), 2);
    chk("edges_cnt0", (xf_cnt.size() > 0) ? xf_cnt[0] : -1, 0);
    chk("onecyc_cnt", (xf_cnt.size() > 1) ? xf_cnt[1] : -1, 1);
`ifdef GATED_COUNTER_GATE_LENGTH_EN
    chk("onecyc_len", (xf_len.size() > 1) ? xf_len[1] : -1, 1);
`endif

    // Back-to-back: rise in the cycle right after fall.
    clear_maps(1'b1, 1'b1);
    set_gate(5, 9);
    set_gate(11, 15);
    set_pulse(6, 1);
    set_pulse(10, 1);
    set_pulse(12, 1);
    run_maps(22);
    chk("b2b_nxfer", xf_cnt.size(), 2);
    chk("b2b_cnt0", (xf_cnt.size() > 0) ? xf_cnt[0] : -1, 1);
    chk("b2b_cnt1", (xf_cnt.size() > 1) ? xf_cnt[1] : -1, 2);

    // Backpressure: three windows with 2, 4 and 6 pulses, ready low.
    clear_maps(1'b1, 1'b0);
    set_gate(5, 18);
    set_gate(22, 35);
    set_gate(39, 52);
    for (int k = 0; k < 2; k++) set_pulse(5 + 2 * k, 1);
    for (int k = 0; k < 4; k++) set_pulse(22 + 2 * k, 1);
    for (int k = 0; k < 6; k++) set_pulse(39 + 2 * k, 1);
    run_maps(60);
    chk("bp_nxfer", xf_cnt.size(), 0);
    chk("bp_hold_cnt", count_out, 2);
    chk("bp_dropped", dropped, 2);
    clear_maps(1'b1, 1'b1);
    run_maps(5);
    chk("bp_drain_n", xf_cnt.size(), 1);
    chk("bp_drain_cnt", (xf_cnt.size() > 0) ? xf_cnt[0] : -1, 2);
    chk("bp_valid_low", valid, 0);

    // Saturation: 20 pulses into a 4-bit counter.
    clear_maps(1'b1, 1'b1);
    set_gate(5, 50);
    for (int k = 0; k < 20; k++) set_pulse(4 + 2 * k, 1);
    run_maps(60);
    chk("sat_nxfer", xf_cnt.size(), 1);
    chk("sat_cnt", (xf_cnt.size() > 0) ? xf_cnt[0] : -1, 15);
    chk("sat_ovf", (xf_ovf.size() > 0) ? xf_ovf[0] : -1, 1);

    // Dropped counter saturation: ten one-cycle windows with ready low.
    clear_maps(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) set_gate(5 + 3 * k, 5 + 3 * k);
    run_maps(40);
    chk("drop_sat", dropped, 7);
    clear_maps(1'b1, 1'b1);
    run_maps(4);

    // Enable: low at the rise (no result), then dropped mid-window (result kept).
    clear_maps(1'b0, 1'b1);
    set_gate(5, 14);
    for (int i = 7; i < 15; i++) emap[i] = 1'b1;
    set_pulse(8, 1);
    set_gate(20, 29);
    emap[20] = 1'b1;
    set_pulse(22, 1);
    run_maps(35);
    chk("en_nxfer", xf_cnt.size(), 1);
    chk("en_cnt", (xf_cnt.size() > 0) ? xf_cnt[0] : -1, 1);

    // Gate high across reset release: no window until a true rise.
    clear_maps(1'b1, 1'b1);
    set_gate(0, 14);
    xmap[2] = 1'b1;
    xmap[3] = 1'b1;
    set_pulse(5, 1);
    set_gate(20, 25);
    set_pulse(21, 1);
    run_maps(32);
    chk("rstgate_nxfer", xf_cnt.size(), 1);
    chk("rstgate_cnt", (xf_cnt.size() > 0) ? xf_cnt[0] : -1, 1);

    // Reset mid-window: window lost, next window counts from scratch.
    clear_maps(1'b1, 1'b1);
    set_gate(5, 14);
    set_pulse(6, 1);
    set_pulse(8, 1);
    xmap[10] = 1'b1;
    xmap[11] = 1'b1;
    set_gate(18, 24);
    set_pulse(19, 1);
    run_maps(30);
    chk("rstmid_nxfer", xf_cnt.size(), 1);
    chk("rstmid_cnt", (xf_cnt.size() > 0) ? xf_cnt[0] : -1, 1);

    // Randomized traffic.
    begin
      bit g = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        bit short_mode;
        short_mode = (c / 500) % 2 == 1;
        if ($urandom_range(short_mode ? 1 : 5, 0) == 0) g = ~g;
        cyc(g, $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0,
            $urandom_range(1, 0) == 1, $urandom_range(499, 0) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gated_pulse_counter.md
# gated_pulse_counter

Counts PMT/photon pulses during the window produced by `delayed_on_gate` and hands one result per window downstream over a valid/ready handshake. It sits directly downstream of `delayed_on_gate`: that block's `q` drives this block's `gate`. The asynchronous detector pulse is synchronised internally. Results go to the readout FIFO / host pipe.

## Interface
- `COUNT_WIDTH`, 32: width of the pulse counter and `count_out`.
- `DROP_WIDTH`, 16: width of the dropped-result counter.
- `clk` in 1: system clock. All logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `gate` in 1: counting window, synchronous to `clk`. Driven by `delayed_on_gate.q`.
- `enable` in 1: arms window start. Sampled only on a gate rising edge.
- `pulse` in 1: asynchronous detector input.
- `count_out` out `COUNT_WIDTH`: pulse count of the last completed window.
- `overflow_out` out 1: counter saturated during that window.
- `valid` out 1: result available.
- `ready` in 1: downstream accepts the result.
- `dropped` out `DROP_WIDTH`: number of results discarded because the output register was full. Saturating.
- `gate_len_out` out 32: gate-high cycle count of the window. Present only with `GATED_COUNTER_GATE_LENGTH_EN`.

## Operation
- Input path:
  - `pulse` passes through two flops, `s1` and `s2`, then `s3`.
  - `edge` = `s2 & ~s3`.
  - `gate_d` is `gate` delayed by one register.
- `rise` = `gate & ~gate_d`. `fall` = `~gate & gate_d`.
- State machine: IDLE, COUNTING.
  - IDLE: on `rise & enable`, go to COUNTING. In that same clock edge, `cnt` <= (`edge` ? 1 : 0) and `ovf` <= 0.
  - IDLE: `rise & ~enable` is ignored. The block stays IDLE for the whole window.
  - COUNTING: while `gate` = 1, `cnt` increments on `edge`. It saturates at all-ones; an `edge` at all-ones sets `ovf`.
  - COUNTING: on `fall`, load the result and go to IDLE.
  - Deasserting `enable` mid-window does not abort the window.
- Result load (at the `fall` edge):
  - If `valid` = 0, or `ready` = 1 in that cycle: `count_out` <= `cnt`, `overflow_out` <= `ovf`, `valid` <= 1.
  - Otherwise the result is discarded and `dropped` increments, saturating at all-ones.
- Handshake:
  - A transfer happens on a clock edge where `valid & ready`.
  - `valid` falls on the next cycle unless a new result loads on that same edge; then `valid` stays 1 with new data.
  - `count_out`, `overflow_out` and `gate_len_out` are stable while `valid & ~ready`.
- Back-to-back windows: a `rise` in the cycle right after `fall` starts a new window normally, with the count restarting from 0 or 1.
- One-cycle gate: this is a legal window. It counts only an `edge` coincident with that cycle.

## Timing
- Reset values:
  - `count_out` = 0, `overflow_out` = 0, `valid` = 0, `dropped` = 0, `gate_len_out` = 0.
  - State = IDLE. `cnt` = 0. `s1`, `s2`, `s3` = 0.
  - `gate_d` = 1, so a gate already high at reset release is not a rising edge. No window starts until the next true rise.
- Reset mid-window: the window is lost and no result is produced.
- Pulse latency: a `pulse` high first sampled at edge N gives `edge` = 1 during cycle N+1→N+2. It is counted if `gate` = 1 in that cycle.
- Result latency: with `gate` first low in cycle T, the result is loaded at the end of cycle T and `valid` = 1 from cycle T+1.
- Throughput: one result per window. The minimum window period is 2 cycles.

## Configuration
- `GATED_COUNTER_GATE_LENGTH_EN` defined:
  - A 32-bit `len` counter resets to 1 on window start.
  - It increments, saturating, on each further `gate`-high cycle in COUNTING.
  - It is loaded into `gate_len_out` together with `count_out`.
- Undefined: the `gate_len_out` port and the `len` logic are absent. All other behaviour is identical.

## Test plan
- Basic window: enable=1, gate high 20 cycles, 5 isolated pulses inside the window (each 3 cycles wide), ready=1.
  - → one `valid` beat with `count_out`=5, `overflow_out`=0.
  - → `gate_len_out`=20 when the macro is defined.
- Edges of the window: pulses whose `edge` falls one cycle before the rise and exactly on the `fall` cycle → not counted. A pulse on the rise cycle → counted.
- Backpressure: ready=0, three windows with 2, 4 and 6 pulses.
  - → `count_out` holds 2, `dropped`=2.
  - → after ready=1, exactly one transfer of 2.
- Saturation: COUNT_WIDTH=4, 20 pulses in one window → `count_out`=15, `overflow_out`=1.
- Gating and enable: enable=0 at the rise → no result. enable drops mid-window → the result is still produced.
- Reset cases:
  - gate high across reset release → no result until gate falls and rises again.
  - `rst` pulsed mid-window → `valid` stays 0 and `cnt` restarts.
